// File: rtl/z80_bus_pkg.sv
// Shared types and constants for the Z80 bus initiator: state encoding,
// the latched command record and the active-low strobe helpers.
package z80_bus_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ,
        T1,
        T2,
        TW,
        T3,
        HOLD,
        REL1,
        REL2
    } state_e;

    typedef struct packed {
        logic        write;
        logic        io;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } cmd_t;

    // Strobe vector order is {mreq_n, iorq_n, rd_n, wr_n}
    localparam logic [3:0] STROBES_OFF = 4'b1111;
    localparam logic       OE_OFF      = 1'b0;

    localparam int DEF_HOLD_CYCLES  = 16;
    localparam int DEF_WAIT_TIMEOUT = 255;
    localparam int CNT_W            = 16;

    function automatic logic [3:0] strobes_for(input cmd_t c);
        return {c.io, !c.io, c.write, !c.write};
    endfunction

endpackage

// File: rtl/z80_sync2.sv
// Two-flop synchronizer for an active-low level; resets to the inactive (1) value.
module z80_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/z80_bus_initiator.sv
// Z80 bus master: acquires the bus with BUSREQ/BUSACK, runs one T1/T2/Tw/T3
// memory or I/O cycle per command and keeps the bus for a hold window.
module z80_bus_initiator
    import z80_bus_pkg::*;
#(
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int WAIT_TIMEOUT = DEF_WAIT_TIMEOUT
) (
    input  logic        i_mclk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_write,
    input  logic        i_cmd_io,
    input  logic [15:0] i_cmd_addr,
    input  logic [7:0]  i_cmd_wdata,
    output logic        o_rsp_valid,
    output logic [7:0]  o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_busreq_n,
    input  logic        i_busack_n,
    input  logic        i_wait_n,
    output logic [15:0] o_addr,
    output logic        o_addr_oe,
    output logic [7:0]  o_data,
    output logic        o_data_oe,
    input  logic [7:0]  i_data,
    output logic        o_mreq_n,
    output logic        o_iorq_n,
    output logic        o_rd_n,
    output logic        o_wr_n
);

    localparam logic [CNT_W-1:0] WAIT_LAST =
        (WAIT_TIMEOUT > 0) ? CNT_W'(WAIT_TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] HOLD_LAST =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    state_e           state;
    cmd_t             cmd;
    cmd_t             cmd_in;
    cmd_t             t1_cmd;
    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             auto_tw;
    logic             busack_s;
    logic             accept;

    z80_sync2 u_busack_sync (
        .clk (i_mclk),
        .rst (i_reset),
        .d   (i_busack_n),
        .q   (busack_s)
    );

    assign accept = i_cmd_valid & o_cmd_ready;

    always_comb begin
        cmd_in       = '0;
        cmd_in.write = i_cmd_write;
        cmd_in.io    = i_cmd_io;
        cmd_in.addr  = i_cmd_addr;
        cmd_in.wdata = i_cmd_wdata;
        // From HOLD the new command launches T1 directly, before it is latched
        t1_cmd       = (state == HOLD) ? cmd_in : cmd;
    end

    always_ff @(posedge i_mclk or posedge i_reset) begin
        if (i_reset) begin
            state       <= IDLE;
            cmd         <= '0;
            wait_cnt    <= '0;
            hold_cnt    <= '0;
            auto_tw     <= 1'b0;
            o_cmd_ready <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_busreq_n  <= 1'b1;
            o_addr      <= '0;
            o_addr_oe   <= OE_OFF;
            o_data      <= '0;
            o_data_oe   <= OE_OFF;
            {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n} <= STROBES_OFF;
        end else begin
            o_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        cmd         <= cmd_in;
                        o_busreq_n  <= 1'b0;
                        o_cmd_ready <= 1'b0;
                        state       <= REQ;
                    end else begin
                        o_cmd_ready <= 1'b1;
                    end
                end

                REQ: begin
                    if (!busack_s) begin
                        o_addr_oe <= 1'b1;
                        o_addr    <= t1_cmd.addr;
                        o_data_oe <= t1_cmd.write;
                        if (t1_cmd.write) o_data <= t1_cmd.wdata;
                        state     <= T1;
                    end
                end

                T1: begin
                    {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n} <= strobes_for(cmd);
                    state <= T2;
                end

                T2: begin
                    wait_cnt <= '0;
                    auto_tw  <= cmd.io;
                    if (cmd.io || !i_wait_n) state <= TW;
                    else                     state <= T3;
                end

                TW: begin
                    if (i_wait_n) begin
                        state <= T3;
                    end else if (auto_tw) begin
                        // The built-in I/O wait state is free of the timeout budget
                        auto_tw <= 1'b0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n} <= STROBES_OFF;
                        o_data_oe   <= OE_OFF;
                        o_rsp_valid <= 1'b1;
                        o_rsp_err   <= 1'b1;
                        o_rsp_rdata <= '0;
                        state       <= HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                T3: begin
                    {o_mreq_n, o_iorq_n, o_rd_n, o_wr_n} <= STROBES_OFF;
                    o_data_oe   <= OE_OFF;
                    o_rsp_valid <= 1'b1;
                    o_rsp_err   <= 1'b0;
                    o_rsp_rdata <= cmd.write ? 8'h00 : i_data;
                    state       <= HOLD;
                end

                HOLD: begin
                    if (o_rsp_valid) begin
                        // Response cycle: ready opens only once the pulse is over
                        hold_cnt <= '0;
                        if (HOLD_CYCLES == 0) begin
                            o_addr_oe <= OE_OFF;
                            state     <= REL1;
                        end else begin
                            o_cmd_ready <= 1'b1;
                        end
                    end else if (accept) begin
                        cmd         <= cmd_in;
                        o_cmd_ready <= 1'b0;
                        o_addr_oe   <= 1'b1;
                        o_addr      <= t1_cmd.addr;
                        o_data_oe   <= t1_cmd.write;
                        if (t1_cmd.write) o_data <= t1_cmd.wdata;
                        state       <= T1;
                    end else if (hold_cnt == HOLD_LAST) begin
                        o_cmd_ready <= 1'b0;
                        o_addr_oe   <= OE_OFF;
                        state       <= REL1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                REL1: begin
                    o_busreq_n <= 1'b1;
                    state      <= REL2;
                end

                REL2: begin
                    // Hold off new requests until the CPU has its bus back
                    if (busack_s) begin
                        o_cmd_ready <= 1'b1;
                        state       <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
